led_mode_scheduler: RTL and testbench
=====================================

Name: led_mode_scheduler

Overview:
- Sequences the 8-LED output stage from the 2-bit SW mode select.
- Synchronises and debounces SW, then commits a mode change only after SW has been stable.
- Generates a prescaled step tick and advances the LED pattern of the active mode on each tick.
- Sits between the board switches/clock and the LED pins; it replaces direct SW-to-LED decoding.

Parameters:
- DIV, 4, prescaler period in Clk cycles per pattern step (>=2).
- DEB, 3, number of consecutive stable synchronised samples required before a mode commit (>=1).

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Rst  in  1  synchronous, active-low reset (Rst=0 at a rising edge resets).
- SW  in  2  raw mode select, asynchronous to Clk.
- En  in  1  step enable; 0 freezes the prescaler and pattern.
- LED  out  8  pattern output, registered.
- Mode  out  2  committed mode, registered.
- Tick  out  1  step strobe; combinational: En && (cnt==DIV-1).
- ModeChg  out  1  one-cycle pulse on the commit edge, registered.

Behaviour:
- Reset (Rst=0 at an edge): sync flops=00, cand=00, deb_cnt=0, Mode=00, state=OFF, cnt=0, LED=0x00, ModeChg=0. Reset overrides every other event, including mid-pattern.
- Sync: SW -> s1 -> s2 (two flops).
- Debounce:
  - If s2!=cand: cand<=s2, deb_cnt<=0.
  - Else if deb_cnt<DEB-1: deb_cnt++.
  - Else if cand!=Mode: commit.
- Commit edge: Mode<=cand, ModeChg<=1, state<=mode state, LED<=seed of that mode, cnt<=0.
- Commit latency: SW changes before edge k -> commit at edge k+2+DEB (k+5 at default).
- Glitch rejection: SW that is stable for fewer than DEB samples never commits.
- Re-selecting the current mode does not commit.
- Prescaler:
  - If En: cnt wraps DIV-1->0, otherwise increments.
  - If !En: cnt holds, Tick=0.
  - Debounce and commit run regardless of En.
- States and step actions (on Tick edge):
  - OFF (00): seed 0x00; LED held at 0x00.
  - LEFT (01): seed 0x01; rotate left, 0x80->0x01.
  - RIGHT (10): seed 0x80; rotate right, 0x01->0x80.
  - BLINK (11): seed 0xFF; LED<=~LED.
- Transitions: any state -> state(cand) on commit only. There are no other transitions.
- Simultaneous commit and Tick: commit wins. LED=new seed, cnt=0, and the step is discarded.
- ModeChg returns to 0 on the edge after the commit.
- Width rules:
  - cnt is $clog2(DIV) bits.
  - deb_cnt is $clog2(DEB)+1 bits, saturating at DEB-1.
  - Rotations are 8-bit circular with no carry.

Decomposition:
- Package led_sched_pkg holds:
  - mode encodings MODE_OFF=2'b00, MODE_LEFT=2'b01, MODE_RIGHT=2'b10, MODE_BLINK=2'b11;
  - seed constants SEED_OFF/LEFT/RIGHT/BLINK;
  - the state enum (OFF, LEFT, RIGHT, BLINK).
- One sub-module, sw_debounce, contains:
  - the 2-flop synchroniser, cand and deb_cnt;
  - parameter DEB;
  - outputs stable_val[1:0] and stable_vld.
- The top level holds the FSM, prescaler, LED register and commit compare.

Test Plan (DIV=4, DEB=3):
- Reset: Rst=0 for 2 edges, SW=00, En=1 -> LED=0x00, Mode=00, ModeChg=0. Tick pulses every 4th cycle; LED stays 0x00.
- SW=01 held:
  - ModeChg pulses for 1 cycle at edge k+5; Mode=01, LED=0x01.
  - Then every 4 cycles: 0x02, 0x04, ... 0x80, 0x01 (wrap).
- Glitch: in LEFT, SW=10 for 2 cycles then back to 01 -> no ModeChg, Mode=01, LED sequence uninterrupted.
- SW=11: LED=0xFF, 0x00, 0xFF alternating every 4 cycles. Then SW=10: ModeChg, LED=0x80, 0x40, ... 0x01, 0x80.
- En=0 in LEFT at LED=0x04 for 10 cycles:
  - LED holds 0x04, Tick=0, cnt frozen.
  - En=1: next step 0x08 after the remaining DIV-1-cnt cycles.
- Commit timed on the cnt==3 edge: LED=seed, cnt=0, no extra step, next step 4 cycles later. Rst=0 mid-RIGHT: next edge LED=0x00, Mode=00, state OFF.

Source files
------------

// File: rtl/led_sched_pkg.sv
// rtl/led_sched_pkg.sv - shared mode encodings, seeds and state type for the LED scheduler
package led_sched_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF   = 2'b00;
    localparam mode_t MODE_LEFT  = 2'b01;
    localparam mode_t MODE_RIGHT = 2'b10;
    localparam mode_t MODE_BLINK = 2'b11;

    localparam logic [7:0] SEED_OFF   = 8'h00;
    localparam logic [7:0] SEED_LEFT  = 8'h01;
    localparam logic [7:0] SEED_RIGHT = 8'h80;
    localparam logic [7:0] SEED_BLINK = 8'hFF;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        LEFT  = 2'b01,
        RIGHT = 2'b10,
        BLINK = 2'b11
    } led_state_t;

    function automatic led_state_t mode_state(input mode_t m);
        case (m)
            MODE_LEFT:  mode_state = LEFT;
            MODE_RIGHT: mode_state = RIGHT;
            MODE_BLINK: mode_state = BLINK;
            default:    mode_state = OFF;
        endcase
    endfunction

    function automatic logic [7:0] mode_seed(input mode_t m);
        case (m)
            MODE_LEFT:  mode_seed = SEED_LEFT;
            MODE_RIGHT: mode_seed = SEED_RIGHT;
            MODE_BLINK: mode_seed = SEED_BLINK;
            default:    mode_seed = SEED_OFF;
        endcase
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - two-flop switch synchroniser with stability counter
module sw_debounce
    import led_sched_pkg::*;
#(
    parameter int DEB = 3
) (
    input  logic  Clk,
    input  logic  Rst,
    input  mode_t SW,
    output mode_t stable_val,
    output logic  stable_vld
);

    localparam int DW = $clog2(DEB) + 1;
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB - 1);

    mode_t s1;
    mode_t s2;
    mode_t cand;
    logic [DW-1:0] deb_cnt;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            s1      <= 2'b00;
            s2      <= 2'b00;
            cand    <= 2'b00;
            deb_cnt <= '0;
        end else begin
            s1 <= SW;
            s2 <= s1;
            if (s2 != cand) begin
                cand    <= s2;
                deb_cnt <= '0;
            end else if (deb_cnt < DEB_MAX) begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    // Valid on the edge where the candidate has just seen its last required sample.
    assign stable_val = cand;
    assign stable_vld = (s2 == cand) && (deb_cnt == DEB_MAX);

endmodule

// File: rtl/led_mode_scheduler.sv
// rtl/led_mode_scheduler.sv - debounced mode commit, step prescaler and LED pattern FSM
module led_mode_scheduler
    import led_sched_pkg::*;
#(
    parameter int DIV = 4,
    parameter int DEB = 3
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] SW,
    input  logic       En,
    output logic [7:0] LED,
    output logic [1:0] Mode,
    output logic       Tick,
    output logic       ModeChg
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    mode_t         stable_val;
    logic          stable_vld;
    logic          commit;
    logic [CW-1:0] cnt;
    led_state_t    state;

    sw_debounce #(.DEB(DEB)) u_deb (
        .Clk        (Clk),
        .Rst        (Rst),
        .SW         (SW),
        .stable_val (stable_val),
        .stable_vld (stable_vld)
    );

    assign Tick   = En && (cnt == CNT_MAX);
    assign commit = stable_vld && (stable_val != Mode);

    // A commit restarts the pattern from its seed and swallows any coincident step.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state   <= OFF;
            Mode    <= MODE_OFF;
            LED     <= SEED_OFF;
            cnt     <= '0;
            ModeChg <= 1'b0;
        end else begin
            ModeChg <= commit;
            if (commit) begin
                Mode  <= stable_val;
                state <= mode_state(stable_val);
                LED   <= mode_seed(stable_val);
                cnt   <= '0;
            end else begin
                if (En) begin
                    cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
                end
                if (Tick) begin
                    case (state)
                        OFF:   LED <= SEED_OFF;
                        LEFT:  LED <= {LED[6:0], LED[7]};
                        RIGHT: LED <= {LED[0], LED[7:1]};
                        BLINK: LED <= ~LED;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_led_mode_scheduler.sv
// tb/tb_led_mode_scheduler.sv - randomized self-checking bench with behavioural model
module tb_led_mode_scheduler;

    localparam int DIV = 4;
    localparam int DEB = 3;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [1:0] SW;
    logic       En;
    logic [7:0] LED;
    logic [1:0] Mode;
    logic       Tick;
    logic       ModeChg;

    int checks = 0;
    int errors = 0;

    led_mode_scheduler #(.DIV(DIV), .DEB(DEB)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .SW      (SW),
        .En      (En),
        .LED     (LED),
        .Mode    (Mode),
        .Tick    (Tick),
        .ModeChg (ModeChg)
    );

    always #5 Clk = ~Clk;

    // Model state: SW pipeline, recent debounce samples, and pattern position.
    logic [1:0] pipe[$];
    logic [1:0] samp[$];
    int m_mode;
    int m_cnt;
    int m_led;
    bit m_chg;
    bit m_valid = 1'b0;

    function automatic int seed_of(input int m);
        case (m)
            1:       return 1;
            2:       return 128;
            3:       return 255;
            default: return 0;
        endcase
    endfunction

    function automatic int step_of(input int m, input int v);
        case (m)
            1:       return (v * 2) % 256 + v / 128;
            2:       return v / 2 + (v % 2) * 128;
            3:       return 255 - v;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_step();
        logic [1:0] s2;
        bit eq;
        if (!Rst) begin
            pipe    = {2'b00, 2'b00};
            samp    = {2'b00};
            m_mode  = 0;
            m_cnt   = 0;
            m_led   = 0;
            m_chg   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            s2 = pipe[0];
            void'(pipe.pop_front());
            pipe.push_back(SW);
            samp.push_back(s2);
            if (samp.size() > DEB + 1) void'(samp.pop_front());
            eq = (samp.size() == DEB + 1);
            foreach (samp[i]) if (samp[i] != samp[0]) eq = 1'b0;
            m_chg = eq && (int'(samp[0]) != m_mode);
            if (m_chg) begin
                m_mode = int'(samp[0]);
                m_led  = seed_of(m_mode);
                m_cnt  = 0;
            end else if (En) begin
                if (m_cnt == DIV - 1) m_led = step_of(m_mode, m_led);
                m_cnt = (m_cnt + 1) % DIV;
            end
        end
    endtask

    task automatic compare();
        if (m_valid) begin
            chk("led", LED, 8'(m_led));
            chk("mode", {6'b0, Mode}, 8'(m_mode));
            chk("modechg", {7'b0, ModeChg}, {7'b0, m_chg});
            chk("tick", {7'b0, Tick}, {7'b0, (En && m_cnt == DIV - 1)});
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        compare();
    endtask

    initial begin
        int n;
        int nchg;
        int kind;
        int len;
        logic [1:0] prev;

        Rst = 1'b0;
        SW  = 2'b00;
        En  = 1'b1;
        tick();
        tick();
        chk("reset_led", LED, 8'h00);
        chk("reset_mode", {6'b0, Mode}, 8'h00);
        chk("reset_chg", {7'b0, ModeChg}, 8'h00);

        Rst = 1'b1;
        repeat (8) tick();
        chk("off_led", LED, 8'h00);

        // Commit lands on the sixth edge counted from the one that first sees SW=01.
        SW = 2'b01;
        n = 0;
        do begin tick(); n++; end while (ModeChg !== 1'b1 && n < 20);
        chk("commit_latency", 8'(n), 8'd6);
        chk("left_seed", LED, 8'h01);
        chk("left_mode", {6'b0, Mode}, 8'h01);
        repeat (4) tick();
        chk("left_step", LED, 8'h02);

        n = 0;
        while (LED !== 8'h04 && n < 20) begin tick(); n++; end
        chk("led_at_freeze", LED, 8'h04);
        En = 1'b0;
        repeat (10) tick();
        chk("frozen_led", LED, 8'h04);
        chk("frozen_tick", {7'b0, Tick}, 8'h00);
        En = 1'b1;
        n = 0;
        do begin tick(); n++; end while (LED === 8'h04 && n < 20);
        chk("resume_cycles", 8'(n), 8'd4);
        chk("resume_led", LED, 8'h08);

        SW = 2'b10;
        nchg = 0;
        repeat (2) begin tick(); nchg += int'(ModeChg); end
        SW = 2'b01;
        repeat (12) begin tick(); nchg += int'(ModeChg); end
        chk("glitch_no_commit", 8'(nchg), 8'd0);
        chk("glitch_mode", {6'b0, Mode}, 8'h01);

        SW = 2'b11;
        n = 0;
        do begin tick(); n++; end while (ModeChg !== 1'b1 && n < 20);
        chk("blink_seed", LED, 8'hFF);
        repeat (4) tick();
        chk("blink_inv", LED, 8'h00);

        SW = 2'b10;
        n = 0;
        do begin tick(); n++; end while (ModeChg !== 1'b1 && n < 20);
        chk("right_seed", LED, 8'h80);
        repeat (4) tick();
        chk("right_step", LED, 8'h40);
        Rst = 1'b0;
        tick();
        chk("midrun_reset_led", LED, 8'h00);
        chk("midrun_reset_mode", {6'b0, Mode}, 8'h00);
        Rst = 1'b1;

        for (int s = 0; s < 400; s++) begin
            kind = $urandom_range(0, 9);
            prev = SW;
            if (kind < 5) begin
                SW  = 2'($urandom_range(0, 3));
                len = $urandom_range(DEB + 2, 16);
            end else if (kind < 9) begin
                SW  = 2'($urandom_range(0, 3));
                len = $urandom_range(1, DEB + 1);
            end else begin
                Rst = 1'b0;
                len = $urandom_range(1, 2);
            end
            for (int c = 0; c < len; c++) begin
                En = ($urandom_range(0, 7) != 0);
                tick();
            end
            Rst = 1'b1;
            if (kind >= 5 && kind < 9) SW = prev;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
